// File: rtl/gate_vector_checker.sv
// gate_vector_checker
//   Stimulus/checker stage wrapped around a 2-input combinational gate.
//   A start pulse begins a sweep. Each of the four input combinations
//   {in_a,in_b} = 00,01,10,11 is held for HOLD_CYCLES cycles. On the last
//   hold cycle the gate output is compared against EXP_TRUTH[{in_a,in_b}].
//   When the sweep ends, the block pulses done and reports err_cnt and pass.
//
// Parameters
//   HOLD_CYCLES  cycles each vector is held before sampling (1..255)
//   EXP_TRUTH    expected gate output indexed by {in_a,in_b}; default = AND
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset; aborts a sweep without done
//   start       begin a sweep; only honoured in IDLE
//   in_a, in_b  registered gate inputs
//   gate_out    gate output under check
//   busy        high while a sweep is driving vectors
//   done        one-cycle pulse at the end of a sweep
//   pass        err_cnt==0 for the last sweep; valid from the done cycle
//   err_cnt     mismatch count of the last sweep (0..4)
//   cur_vec     vector index {in_a,in_b} currently driven
//   first_fail  (only with GVC_FIRST_FAIL_EN) {seen, vector of first mismatch}
//
// Optional feature macro: GVC_FIRST_FAIL_EN adds the first_fail output.

module gate_vector_checker #(
  parameter int unsigned HOLD_CYCLES = 10,
  parameter logic [3:0]  EXP_TRUTH   = 4'b1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       in_a,
  output logic       in_b,
  input  logic       gate_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [1:0] cur_vec
`ifdef GVC_FIRST_FAIL_EN
  ,
  output logic [2:0] first_fail
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state_q,   state_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [1:0] cur_vec_q, cur_vec_d;
  logic [2:0] err_cnt_q, err_cnt_d;
  logic       in_a_q,    in_a_d;
  logic       in_b_q,    in_b_d;
  logic       busy_q,    busy_d;
  logic       done_q,    done_d;
  logic       pass_q,    pass_d;
  logic       mismatch;
`ifdef GVC_FIRST_FAIL_EN
  logic [2:0] first_fail_q, first_fail_d;
`endif

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    cur_vec_d  = cur_vec_q;
    err_cnt_d  = err_cnt_q;
    in_a_d     = in_a_q;
    in_b_d     = in_b_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    mismatch   = 1'b0;
`ifdef GVC_FIRST_FAIL_EN
    first_fail_d = first_fail_q;
`endif

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        in_a_d = 1'b0;
        in_b_d = 1'b0;
        if (start) begin
          state_d    = ST_DRIVE;
          cur_vec_d  = 2'd0;
          err_cnt_d  = 3'd0;
          pass_d     = 1'b0;
          hold_cnt_d = 8'd0;
          busy_d     = 1'b1;
`ifdef GVC_FIRST_FAIL_EN
          first_fail_d = 3'd0;
`endif
        end
      end

      ST_DRIVE: begin
        busy_d = 1'b1;
        if (hold_cnt_q == HOLD_LAST) begin
          // Sample point: gate_out reflects the vector held this cycle.
          mismatch = (gate_out != EXP_TRUTH[cur_vec_q]);
          if (mismatch && (err_cnt_q != 3'd4)) begin
            err_cnt_d = err_cnt_q + 3'd1;
          end
`ifdef GVC_FIRST_FAIL_EN
          if (mismatch && !first_fail_q[2]) begin
            first_fail_d = {1'b1, cur_vec_q};
          end
`endif
          hold_cnt_d = 8'd0;
          if (cur_vec_q != 2'd3) begin
            cur_vec_d = cur_vec_q + 2'd1;
            in_a_d    = cur_vec_d[1];
            in_b_d    = cur_vec_d[0];
          end else begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            in_a_d    = 1'b0;
            in_b_d    = 1'b0;
            cur_vec_d = 2'd0;
            // Include the final vector's result in the verdict.
            pass_d    = (err_cnt_d == 3'd0);
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end

      ST_DONE: begin
        // start is deliberately ignored here; always fall back to IDLE.
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        in_a_d  = 1'b0;
        in_b_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        in_a_d  = 1'b0;
        in_b_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= 8'd0;
      cur_vec_q  <= 2'd0;
      err_cnt_q  <= 3'd0;
      in_a_q     <= 1'b0;
      in_b_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
`ifdef GVC_FIRST_FAIL_EN
      first_fail_q <= 3'd0;
`endif
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      cur_vec_q  <= cur_vec_d;
      err_cnt_q  <= err_cnt_d;
      in_a_q     <= in_a_d;
      in_b_q     <= in_b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
`ifdef GVC_FIRST_FAIL_EN
      first_fail_q <= first_fail_d;
`endif
    end
  end

  assign in_a    = in_a_q;
  assign in_b    = in_b_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_cnt_q;
  assign cur_vec = cur_vec_q;
`ifdef GVC_FIRST_FAIL_EN
  assign first_fail = first_fail_q;
`endif

endmodule

// File: tb/tb_gate_vector_checker.sv
// tb_gate_vector_checker
//   Directed bench for gate_vector_checker. dut_a (HOLD_CYCLES=10, AND truth
//   table) sees a selectable gate: a real AND, stuck-at-0 or stuck-at-1.
//   dut_x (HOLD_CYCLES=1, XOR truth table) is wired to an AND gate, so it
//   should report three mismatches. Expected values are hand-derived.

module tb_gate_vector_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_a, start_x;

  // dut_a signals
  logic       in_a_a, in_b_a, busy_a, done_a, pass_a, gate_a;
  logic [2:0] err_a;
  logic [1:0] vec_a;
  logic [1:0] gmode;  // 0 = AND model, 1 = stuck 0, 2 = stuck 1

  // dut_x signals
  logic       in_a_x, in_b_x, busy_x, done_x, pass_x, gate_x;
  logic [2:0] err_x;
  logic [1:0] vec_x;

`ifdef GVC_FIRST_FAIL_EN
  logic [2:0] ff_a, ff_x;
`endif

  assign gate_a = (gmode == 2'd0) ? (in_a_a & in_b_a) : (gmode == 2'd2);
  assign gate_x = in_a_x & in_b_x;

  gate_vector_checker #(.HOLD_CYCLES(10), .EXP_TRUTH(4'b1000)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .in_a(in_a_a), .in_b(in_b_a), .gate_out(gate_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_cnt(err_a), .cur_vec(vec_a)
`ifdef GVC_FIRST_FAIL_EN
    , .first_fail(ff_a)
`endif
  );

  gate_vector_checker #(.HOLD_CYCLES(1), .EXP_TRUTH(4'b0110)) dut_x (
    .clk(clk), .rst_n(rst_n), .start(start_x),
    .in_a(in_a_x), .in_b(in_b_x), .gate_out(gate_x),
    .busy(busy_x), .done(done_x), .pass(pass_x),
    .err_cnt(err_x), .cur_vec(vec_x)
`ifdef GVC_FIRST_FAIL_EN
    , .first_fail(ff_x)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full sweep on dut_a. Cycle k is the cycle following edge E+k,
  // where E is the edge that samples start.
  task automatic sweep_a(input logic [1:0] mode, input bit extra,
                         input logic [2:0] exp_err, input logic [2:0] exp_ff);
    logic [5:0] expv;
    logic [1:0] v;
    gmode   = mode;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 0; k <= 42; k++) begin
      if (k < 40) begin
        v    = 2'(k / 10);
        expv = {1'b1, 1'b0, v[1], v[0], v};
      end else if (k == 40) begin
        expv = 6'b010000;
      end else begin
        expv = 6'b000000;
      end
      check_eq($sformatf("a_ctl_m%0d_c%0d", mode, k),
               {26'd0, busy_a, done_a, in_a_a, in_b_a, vec_a}, {26'd0, expv});
      if (k == 40 || k == 42) begin
        check_eq($sformatf("a_err_m%0d_c%0d", mode, k), {29'd0, err_a}, {29'd0, exp_err});
        check_eq($sformatf("a_pass_m%0d_c%0d", mode, k), {31'd0, pass_a},
                 {31'd0, (exp_err == 3'd0)});
`ifdef GVC_FIRST_FAIL_EN
        check_eq($sformatf("a_ff_m%0d_c%0d", mode, k), {29'd0, ff_a}, {29'd0, exp_ff});
`endif
      end
      // Stray starts: one mid-sweep, one during the done cycle.
      start_a = extra && (k == 5 || k == 40);
      tick();
    end
    start_a = 1'b0;
    $display("sweep dut_a mode=%0d extra=%0b err_cnt=%0d pass=%0b (exp err_cnt=%0d ff=%0h)",
             mode, extra, err_a, pass_a, exp_err, exp_ff);
  endtask

  initial begin
    logic [1:0] v;
    logic [5:0] expv;
    int done_seen;

    rst_n   = 1'b0;
    start_a = 1'b0;
    start_x = 1'b0;
    gmode   = 2'd0;
    repeat (3) tick();

    // Reset state
    check_eq("rst_a", {23'd0, busy_a, done_a, pass_a, in_a_a, in_b_a, err_a, vec_a}, 32'd0);
    check_eq("rst_x", {23'd0, busy_x, done_x, pass_x, in_a_x, in_b_x, err_x, vec_x}, 32'd0);
`ifdef GVC_FIRST_FAIL_EN
    check_eq("rst_ff_a", {29'd0, ff_a}, 32'd0);
`endif
    rst_n = 1'b1;
    tick();
    $display("reset released");

    // Good AND, stuck-at-0, stuck-at-1 (with stray starts), good again.
    sweep_a(2'd0, 1'b0, 3'd0, 3'b000);
    sweep_a(2'd1, 1'b0, 3'd1, 3'b111);
    sweep_a(2'd2, 1'b1, 3'd3, 3'b100);
    sweep_a(2'd0, 1'b1, 3'd0, 3'b000);

    // Reset in the middle of a sweep (stuck-at-1 so err_cnt is nonzero first).
    gmode   = 2'd2;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (15) tick();
    check_eq("mid_err_before_rst", {29'd0, err_a}, 32'd1);
    check_eq("mid_busy_before_rst", {31'd0, busy_a}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("mid_rst_state",
             {23'd0, busy_a, done_a, pass_a, in_a_a, in_b_a, err_a, vec_a}, 32'd0);
`ifdef GVC_FIRST_FAIL_EN
    check_eq("mid_rst_ff", {29'd0, ff_a}, 32'd0);
`endif
    done_seen = 0;
    for (int k = 0; k < 45; k++) begin
      if (done_a || busy_a) done_seen++;
      tick();
    end
    check_eq("mid_rst_no_done", done_seen, 32'd0);
    $display("mid-sweep reset: activity cycles after reset=%0d", done_seen);
    sweep_a(2'd0, 1'b0, 3'd0, 3'b000);

    // XOR expectation, AND gate connected, one cycle per vector.
    start_x = 1'b1;
    tick();
    start_x = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      if (k < 4) begin
        v    = 2'(k);
        expv = {1'b1, 1'b0, v[1], v[0], v};
      end else if (k == 4) begin
        expv = 6'b010000;
      end else begin
        expv = 6'b000000;
      end
      check_eq($sformatf("x_ctl_c%0d", k),
               {26'd0, busy_x, done_x, in_a_x, in_b_x, vec_x}, {26'd0, expv});
      if (k == 4) begin
        check_eq("x_err", {29'd0, err_x}, 32'd3);
        check_eq("x_pass", {31'd0, pass_x}, 32'd0);
`ifdef GVC_FIRST_FAIL_EN
        check_eq("x_ff", {29'd0, ff_x}, 32'b101);
`endif
      end
      tick();
    end
    $display("sweep dut_x err_cnt=%0d pass=%0b (exp err_cnt=3 pass=0)", err_x, pass_x);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
